// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// datapath mux codes and the control word produced for each state.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUB_REG     = 2'b00,
    ALUB_FOUR    = 2'b01,
    ALUB_IMM     = 2'b10,
    ALUB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  // pc_write_on_ready marks the PC update that must wait for the fetch to land.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_on_ready;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
  } ctrl_word_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Purely combinational map from FSM state to the datapath control word.
// Memory-ready gating is applied by the caller.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read          = 1'b1;
        cw.alu_src_b         = ALUB_FOUR;
        cw.ir_write          = 1'b1;
        cw.pc_write_on_ready = 1'b1;
      end
      S_DECODE: begin
        cw.alu_src_b = ALUB_IMM_SH2;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        cw.mem_read  = 1'b1;
        cw.iord      = 1'b1;
        cw.mdr_write = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUB_IMM;
      end
      S_ADDIWB: begin
        cw.reg_write = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle MIPS control FSM: state register, next-state logic,
// memory-ready gating of enables and PC enable composition.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MDRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0] state_reg;
  state_e             state_cur;
  state_e             state_next;
  logic               is_load_reg;
  logic               is_load_next;
  logic               illegal_raw;
  ctrl_word_t         cw;

  assign state_cur = state_e'(state_reg[3:0]);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg   <= STATE_W'(S_FETCH);
      is_load_reg <= 1'b0;
    end else begin
      state_reg   <= STATE_W'(state_next);
      is_load_reg <= is_load_next;
    end
  end

  // lw/sw split is remembered from DECODE so Opcode is only looked at there.
  always_comb begin
    state_next   = state_cur;
    is_load_next = is_load_reg;
    illegal_raw  = 1'b0;
    case (state_cur)
      S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_load_next = (Opcode == OP_LW);
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_next = is_load_reg ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state (state_cur),
    .cw    (cw)
  );

  // Reset masks every strobe and enable combinationally, ahead of the clock.
  assign PCEn     = ~Rst & (cw.pc_write | (cw.pc_write_on_ready & MemReady) |
                            (cw.pc_write_cond & Zero));
  assign IRWrite  = ~Rst & cw.ir_write & MemReady;
  assign MDRWrite = ~Rst & cw.mdr_write & MemReady;
  assign RegWrite = ~Rst & cw.reg_write;
  assign MemRead  = ~Rst & cw.mem_read;
  assign MemWrite = ~Rst & cw.mem_write;
  assign Illegal  = ~Rst & illegal_raw;

  assign IorD     = cw.iord;
  assign MemtoReg = cw.mem_to_reg;
  assign RegDst   = cw.reg_dst;
  assign ALUSrcA  = cw.alu_src_a;
  assign ALUSrcB  = cw.alu_src_b;
  assign ALUOp    = cw.alu_op;
  assign PCSource = cw.pc_source;
  assign State    = state_reg;

endmodule
